gate_eval_scheduler: RTL and testbench

- Round-robin scheduler that shares one external multi-input NAND gate evaluator among NUM_REQ requesters.
- Each requester submits an INPUT_COUNT-bit lamp vector. The scheduler grants one request at a time, drives the shared gate input, and waits a fixed evaluation latency.
- It then samples the gate result and returns it to the granted requester with a one-cycle response pulse.
- Sits between wire-propagation logic and a shared gate instance, so many logical gates can be serialised onto one evaluator.

---
 rtl/gate_eval_scheduler.sv | 160 ++++++++++++++++
 tb/tb_gate_eval_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_eval_scheduler.sv
// gate_eval_scheduler: round-robin arbiter that serialises NUM_REQ requesters onto one
// shared multi-input gate evaluator. It latches the winning lamp vector onto gate_in and
// waits EVAL_LATENCY cycles. It then samples gate_out and returns the result to the
// winning requester with a one-cycle rsp_valid pulse.
// Optional build macro GATE_SCHED_STATS_EN adds a saturating eval_count output.
module gate_eval_scheduler #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned INPUT_COUNT  = 2,
    parameter int unsigned EVAL_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           logic_reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*INPUT_COUNT-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [INPUT_COUNT-1:0]         gate_in,
    input  logic                           gate_out,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic                           rsp_data,
    output logic                           busy
`ifdef GATE_SCHED_STATS_EN
    ,
    output logic [15:0]                    eval_count
`endif
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [INPUT_COUNT-1:0] gate_in_q, gate_in_d;
    logic [IdxW-1:0]        grant_q, grant_d;
    logic [IdxW-1:0]        last_grant_q, last_grant_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   rsp_data_q, rsp_data_d;

    logic                   sel_found;
    logic [IdxW-1:0]        sel_idx;
    logic [IdxW-1:0]        cand_idx;
    logic [INPUT_COUNT-1:0] sel_data;
    logic [INPUT_COUNT-1:0] req_slice [NUM_REQ];

    // Unpack the flat request bus so the arbiter can index a requester directly.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_slice[g] = req_data[g*INPUT_COUNT +: INPUT_COUNT];
    end

    // Round-robin pick: first valid requester scanning upward from last_grant+1, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_data  = '0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IdxW'((32'(last_grant_q) + k) % NUM_REQ);
            if (!sel_found && req_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
                sel_data  = req_slice[cand_idx];
            end
        end
    end

    // Next-state logic: accept in idle, count down the evaluator latency, then respond.
    always_comb begin
        state_d      = state_q;
        gate_in_d    = gate_in_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    gate_in_d = sel_data;
                    grant_d   = sel_idx;
                    cnt_d     = 3'(EVAL_LATENCY);
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    rsp_data_d = gate_out;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (!logic_reset) begin
            state_q      <= StIdle;
            gate_in_q    <= '0;
            grant_q      <= '0;
            last_grant_q <= IdxW'(NUM_REQ - 1);
            cnt_q        <= '0;
            rsp_data_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_in_q    <= gate_in_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // Outputs: ready is combinational in idle and held low while reset is asserted.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (logic_reset && (state_q == StIdle) && sel_found) begin
            req_ready[sel_idx] = 1'b1;
        end
        if (state_q == StResp) begin
            rsp_valid[grant_q] = 1'b1;
        end
    end

    assign gate_in  = gate_in_q;
    assign rsp_data = rsp_data_q;
    assign busy     = (state_q != StIdle);

`ifdef GATE_SCHED_STATS_EN
    logic [15:0] eval_count_q, eval_count_d;

    // Count completed responses, saturating at all-ones.
    always_comb begin
        eval_count_d = eval_count_q;
        if ((state_q == StResp) && (eval_count_q != 16'hFFFF)) begin
            eval_count_d = eval_count_q + 16'd1;
        end
    end

    // Statistics register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!logic_reset) begin
            eval_count_q <= '0;
        end else begin
            eval_count_q <= eval_count_d;
        end
    end

    assign eval_count = eval_count_q;
`endif

endmodule

// File: tb/tb_gate_eval_scheduler.sv
// Bench for gate_eval_scheduler: directed steps plus random traffic against a
// transaction-level model (rotation pick, fixed response delay, NAND result).
module tb_gate_eval_scheduler;

    localparam int L1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       logic_reset;
    logic [3:0] rv1, rv0, rv7;
    logic [7:0] rd1, rd0, rd7;
    logic [3:0] rr1, rr0, rr7, rs1, rs0, rs7;
    logic [1:0] gi1, gi0, gi7;
    logic       go1, go0, go7, rdat1, rdat0, rdat7, busy1, busy0, busy7;
`ifdef GATE_SCHED_STATS_EN
    logic [15:0] ec1, ec0, ec7;
`endif

    // Shared evaluators: plain 2-input NAND gates.
    assign go1 = ~&gi1;
    assign go0 = ~&gi0;
    assign go7 = ~&gi7;

    gate_eval_scheduler #(.NUM_REQ(4), .INPUT_COUNT(2), .EVAL_LATENCY(1)) dut1 (
        .clk(clk), .logic_reset(logic_reset), .req_valid(rv1), .req_data(rd1),
        .req_ready(rr1), .gate_in(gi1), .gate_out(go1), .rsp_valid(rs1),
        .rsp_data(rdat1), .busy(busy1)
`ifdef GATE_SCHED_STATS_EN
        , .eval_count(ec1)
`endif
    );

    gate_eval_scheduler #(.NUM_REQ(4), .INPUT_COUNT(2), .EVAL_LATENCY(0)) dut0 (
        .clk(clk), .logic_reset(logic_reset), .req_valid(rv0), .req_data(rd0),
        .req_ready(rr0), .gate_in(gi0), .gate_out(go0), .rsp_valid(rs0),
        .rsp_data(rdat0), .busy(busy0)
`ifdef GATE_SCHED_STATS_EN
        , .eval_count(ec0)
`endif
    );

    gate_eval_scheduler #(.NUM_REQ(4), .INPUT_COUNT(2), .EVAL_LATENCY(7)) dut7 (
        .clk(clk), .logic_reset(logic_reset), .req_valid(rv7), .req_data(rd7),
        .req_ready(rr7), .gate_in(gi7), .gate_out(go7), .rsp_valid(rs7),
        .rsp_data(rdat7), .busy(busy7)
`ifdef GATE_SCHED_STATS_EN
        , .eval_count(ec7)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model of dut1 at transaction level.
    int         cyc, next_free, last, rsp_cycle, rsp_idx, gate_upd_cycle, n_resp;
    logic       rsp_val_exp, cur_rsp;
    logic [1:0] gate_exp, gate_next;
    logic [3:0] pending;
    logic [1:0] pdata [4];
    int         obs_g[$];
    int         obs_gc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        next_free      = cyc + 1;
        last           = 3;
        rsp_cycle      = -1;
        gate_upd_cycle = -1;
        gate_exp       = 2'b00;
        cur_rsp        = 1'b0;
        n_resp         = 0;
    endtask

    // One clock cycle of dut1: new requests, withdrawals, optional reset, full check.
    task automatic cycle1(input logic [3:0] newreq, input logic [7:0] ndata,
                          input logic [3:0] wd, input bit rst);
        logic [3:0] exp_ready;
        logic [3:0] exp_rsp;
        int pick;
        @(negedge clk);
        cyc++;
        pending = pending & ~wd;
        for (int i = 0; i < 4; i++) begin
            if (newreq[i] && !pending[i]) begin
                pending[i] = 1'b1;
                pdata[i]   = ndata[2*i +: 2];
            end
        end
        logic_reset = !rst;
        rv1 = pending;
        for (int i = 0; i < 4; i++) rd1[2*i +: 2] = pdata[i];
        if (gate_upd_cycle == cyc) gate_exp = gate_next;
        if (rsp_cycle == cyc) cur_rsp = rsp_val_exp;
        #1;
        exp_ready = 4'b0;
        pick = -1;
        if (!rst && cyc >= next_free && pending != 4'b0) begin
            for (int k = 1; k <= 4; k++) begin
                if (pick < 0 && pending[(last + k) % 4]) pick = (last + k) % 4;
            end
            exp_ready[pick] = 1'b1;
        end
        exp_rsp = 4'b0;
        if (rsp_cycle == cyc) exp_rsp[rsp_idx] = 1'b1;
        chk("req_ready", 32'(rr1), 32'(exp_ready));
        chk("rsp_valid", 32'(rs1), 32'(exp_rsp));
        chk("busy", 32'(busy1), 32'(cyc < next_free));
        chk("gate_in", 32'(gi1), 32'(gate_exp));
        chk("rsp_data", 32'(rdat1), 32'(cur_rsp));
        for (int i = 0; i < 4; i++) begin
            if (rr1[i]) begin
                obs_g.push_back(i);
                obs_gc.push_back(cyc);
            end
        end
        if (rsp_cycle == cyc && !rst) n_resp++;
        if (pick >= 0) begin
            last           = pick;
            rsp_cycle      = cyc + L1 + 2;
            rsp_idx        = pick;
            rsp_val_exp    = ~&pdata[pick];
            next_free      = cyc + L1 + 3;
            gate_next      = pdata[pick];
            gate_upd_cycle = cyc + 1;
            pending[pick]  = 1'b0;
        end
        if (rst) model_reset();
    endtask

    // Single request on the latency-0 or latency-7 instance; measures response delay.
    task automatic lat_test(input int which, input int lat, input int idx, input logic [1:0] d);
        logic [3:0] rdy, rsp;
        logic       rdat;
        int         found;
        @(negedge clk);
        if (which == 0) begin
            rv0 = 4'(32'(1) << idx);
            rd0 = {4{d}};
        end else begin
            rv7 = 4'(32'(1) << idx);
            rd7 = {4{d}};
        end
        #1;
        rdy = (which == 0) ? rr0 : rr7;
        chk("lat_ready", 32'(rdy), 32'(1) << idx);
        found = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            rv0 = 4'b0;
            rv7 = 4'b0;
            #1;
            rsp  = (which == 0) ? rs0 : rs7;
            rdat = (which == 0) ? rdat0 : rdat7;
            if (rsp != 4'b0 && found < 0) begin
                found = n;
                chk("lat_rsp_valid", 32'(rsp), 32'(1) << idx);
                chk("lat_rsp_data", 32'(rdat), 32'(~&d));
            end
        end
        chk("lat_cycles", 32'(found), 32'(lat + 2));
    endtask

    initial begin
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        logic_reset = 1'b0;
        rv1 = 4'b0; rv0 = 4'b0; rv7 = 4'b0;
        rd1 = 8'b0; rd0 = 8'b0; rd7 = 8'b0;
        pending = 4'b0;
        for (int i = 0; i < 4; i++) pdata[i] = 2'b00;
        rsp_val_exp = 1'b0;
        gate_next = 2'b00;
        rsp_idx = 0;
        @(posedge clk);
        cyc = 0;
        model_reset();

        // Reset held with every requester valid.
        for (int i = 0; i < 3; i++) cycle1(4'hF, 8'($urandom), 4'h0, 1'b1);

        // Contention: all four held; expect grants 0,1,2,3,0 every four cycles.
        obs_g.delete();
        obs_gc.delete();
        for (int i = 0; i < 17; i++) cycle1(4'hF, 8'($urandom), 4'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("grant_order", (k < obs_g.size()) ? 32'(obs_g[k]) : 32'd99, 32'(exp_order[k]));
        end
        for (int k = 1; k < 5; k++) begin
            chk("grant_spacing",
                (k < obs_gc.size()) ? 32'(obs_gc[k] - obs_gc[k-1]) : 32'd99, 32'd4);
        end
        cycle1(4'h0, 8'h00, 4'hF, 1'b0);
        for (int i = 0; i < 6; i++) cycle1(4'h0, 8'h00, 4'h0, 1'b0);
`ifdef GATE_SCHED_STATS_EN
        chk("eval_count_5", 32'(ec1), 32'd5);
`endif

        // Single requests: NAND(11)=0 then NAND(01)=1.
        cycle1(4'b0100, 8'b0011_0000, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) cycle1(4'h0, 8'h00, 4'h0, 1'b0);
        cycle1(4'b0100, 8'b0001_0000, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) cycle1(4'h0, 8'h00, 4'h0, 1'b0);

        // Reset in the wait cycle abandons the request; requester 0 then wins over 3.
        cycle1(4'b1000, 8'b1000_0000, 4'h0, 1'b0);
        cycle1(4'h0, 8'h00, 4'h0, 1'b1);
        obs_g.delete();
        obs_gc.delete();
        cycle1(4'b1001, 8'b1100_0010, 4'h0, 1'b0);
        chk("post_reset_winner", (obs_g.size() > 0) ? 32'(obs_g[0]) : 32'd99, 32'd0);
        for (int i = 0; i < 10; i++) cycle1(4'h0, 8'h00, 4'h0, 1'b0);

        // Random traffic with withdrawals and occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle1(4'($urandom & $urandom), 8'($urandom),
                   4'($urandom & $urandom & $urandom), ($urandom_range(0, 59) == 0));
        end
        cycle1(4'h0, 8'h00, 4'hF, 1'b0);
        for (int i = 0; i < 6; i++) cycle1(4'h0, 8'h00, 4'h0, 1'b0);
`ifdef GATE_SCHED_STATS_EN
        chk("eval_count", 32'(ec1), 32'(n_resp));
`endif

        // Latency extremes on the dedicated instances.
        lat_test(0, 0, 1, 2'b11);
        lat_test(0, 0, 2, 2'b10);
        lat_test(1, 7, 3, 2'b00);
        lat_test(1, 7, 0, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
